// File: rtl/cpu_bus_ctrl.sv
// CPU strobe-bus controller: resynchronises cs_n/oe_n/we_n and runs the read/write FSM for three config registers.
// Optional HOLD-state timeout is built only when BUS_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module cpu_bus_ctrl #(
   parameter int TIMEOUT_CYC = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs_n,
   input  logic       oe_n,
   input  logic       we_n,
   input  logic [1:0] addr,
   input  logic [7:0] din,
   output logic [7:0] dout,
   output logic       dout_en,
   output logic       ack,
   output logic       my_rd,
   output logic       my_wr,
   output logic       cs_reg1,
   output logic       cs_reg2,
   output logic       cs_reg3,
   output logic [7:0] reg1,
   output logic [7:0] reg2,
   output logic [7:0] reg3,
   output logic [7:0] status
);

   typedef enum logic [2:0] {IDLE, SETUP, RD, WR, HOLD, ERR} state_t;

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be in 1..255");
   end

   logic [1:0] cs_sync_q, oe_sync_q, we_sync_q;
   logic       cs_s, oe_s, we_s;
   state_t     state_q;
   logic       is_rd_q;
   logic [1:0] addr_q;
   logic [7:0] din_q;
   logic [7:0] dout_q, reg1_q, reg2_q, reg3_q;
   logic       dout_en_q, ack_q, my_rd_q, my_wr_q;
   logic       cs_reg1_q, cs_reg2_q, cs_reg3_q;
   logic       err_cf_q;
   logic       err_to;
   logic       rel_d;

   // Two-flop synchronisers, idle-high so a reset never looks like a strobe
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cs_sync_q <= 2'b11;
         oe_sync_q <= 2'b11;
         we_sync_q <= 2'b11;
      end else begin
         cs_sync_q <= {cs_sync_q[0], cs_n};
         oe_sync_q <= {oe_sync_q[0], oe_n};
         we_sync_q <= {we_sync_q[0], we_n};
      end
   end

   assign cs_s   = cs_sync_q[1];
   assign oe_s   = oe_sync_q[1];
   assign we_s   = we_sync_q[1];
   assign rel_d  = cs_s || (is_rd_q ? oe_s : we_s);
   assign status = {6'b0, err_to, err_cf_q};

`ifdef BUS_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
   logic [7:0] to_cnt_q;
   logic       err_to_q;
   assign err_to = err_to_q;
`else
   assign err_to = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         is_rd_q   <= 1'b0;
         addr_q    <= 2'd0;
         din_q     <= 8'd0;
         dout_q    <= 8'd0;
         dout_en_q <= 1'b0;
         ack_q     <= 1'b0;
         my_rd_q   <= 1'b0;
         my_wr_q   <= 1'b0;
         cs_reg1_q <= 1'b0;
         cs_reg2_q <= 1'b0;
         cs_reg3_q <= 1'b0;
         reg1_q    <= 8'd0;
         reg2_q    <= 8'd0;
         reg3_q    <= 8'd0;
         err_cf_q  <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         to_cnt_q  <= 8'd0;
         err_to_q  <= 1'b0;
`endif
      end else begin
         my_wr_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
         if (state_q != HOLD) to_cnt_q <= 8'd0;
`endif
         case (state_q)
            IDLE: begin
               if (!cs_s) begin
                  if (!oe_s && !we_s) begin
                     err_cf_q <= 1'b1;
                     state_q  <= ERR;
                  end else if (oe_s != we_s) begin
                     is_rd_q <= !oe_s;
                     state_q <= SETUP;
                  end
               end
            end
            SETUP: begin
               addr_q    <= addr;
               din_q     <= din;
               cs_reg1_q <= (addr == 2'd1);
               cs_reg2_q <= (addr == 2'd2);
               cs_reg3_q <= (addr == 2'd3);
               if (is_rd_q) begin
                  my_rd_q <= 1'b1;
                  state_q <= RD;
               end else begin
                  my_wr_q <= 1'b1;
                  state_q <= WR;
               end
            end
            RD: begin
               case (addr_q)
                  2'd1:    dout_q <= reg1_q;
                  2'd2:    dout_q <= reg2_q;
                  2'd3:    dout_q <= reg3_q;
                  default: dout_q <= status;
               endcase
               dout_en_q <= 1'b1;
               ack_q     <= 1'b1;
               state_q   <= HOLD;
            end
            WR: begin
               case (addr_q)
                  2'd1: reg1_q <= din_q;
                  2'd2: reg2_q <= din_q;
                  2'd3: reg3_q <= din_q;
                  default: begin
                     if (din_q[0]) err_cf_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
                     if (din_q[1]) err_to_q <= 1'b0;
`endif
                  end
               endcase
               ack_q   <= 1'b1;
               state_q <= HOLD;
            end
            HOLD: begin
               if (rel_d) begin
                  ack_q     <= 1'b0;
                  dout_en_q <= 1'b0;
                  dout_q    <= 8'd0;
                  my_rd_q   <= 1'b0;
                  cs_reg1_q <= 1'b0;
                  cs_reg2_q <= 1'b0;
                  cs_reg3_q <= 1'b0;
                  state_q   <= IDLE;
               end
`ifdef BUS_TIMEOUT_EN
               else if (to_cnt_q == TO_LAST) begin
                  // Stuck strobe: abandon the access and park in ERR until release
                  err_to_q  <= 1'b1;
                  ack_q     <= 1'b0;
                  dout_en_q <= 1'b0;
                  dout_q    <= 8'd0;
                  my_rd_q   <= 1'b0;
                  cs_reg1_q <= 1'b0;
                  cs_reg2_q <= 1'b0;
                  cs_reg3_q <= 1'b0;
                  state_q   <= ERR;
               end else begin
                  to_cnt_q <= to_cnt_q + 8'd1;
               end
`endif
            end
            ERR: begin
               if (cs_s || (oe_s && we_s)) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dout    = dout_q;
   assign dout_en = dout_en_q;
   assign ack     = ack_q;
   assign my_rd   = my_rd_q;
   assign my_wr   = my_wr_q;
   assign cs_reg1 = cs_reg1_q;
   assign cs_reg2 = cs_reg2_q;
   assign cs_reg3 = cs_reg3_q;
   assign reg1    = reg1_q;
   assign reg2    = reg2_q;
   assign reg3    = reg3_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: write/read timing, decode, conflict flag, W1C, mid-access reset, optional timeout.
`timescale 1ns/1ps
module tb_cpu_bus_ctrl;

`ifdef BUS_TIMEOUT_EN
   localparam int TO_CYC = 4;
`else
   localparam int TO_CYC = 255;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cs_n = 1'b1, oe_n = 1'b1, we_n = 1'b1;
   logic [1:0] addr = 2'd0;
   logic [7:0] din = 8'd0;
   logic [7:0] dout, reg1, reg2, reg3, status;
   logic       dout_en, ack, my_rd, my_wr, cs_reg1, cs_reg2, cs_reg3;
   logic [7:0] q;
   int         n_tests = 0;
   int         n_fail  = 0;

   cpu_bus_ctrl #(.TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst(rst), .cs_n(cs_n), .oe_n(oe_n), .we_n(we_n),
      .addr(addr), .din(din), .dout(dout), .dout_en(dout_en), .ack(ack),
      .my_rd(my_rd), .my_wr(my_wr), .cs_reg1(cs_reg1), .cs_reg2(cs_reg2),
      .cs_reg3(cs_reg3), .reg1(reg1), .reg2(reg2), .reg3(reg3), .status(status)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance n rising edges and sample 1ns after the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_access(input bit rd, input logic [1:0] a, input logic [7:0] d,
                             output logic [7:0] rdata);
      bit seen = 1'b0;
      @(negedge clk);
      addr = a; din = d; cs_n = 1'b0;
      if (rd) oe_n = 1'b0; else we_n = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step(1);
         seen = ack;
      end
      chk("acc_ack_seen", {31'd0, seen}, 32'd1);
      rdata = dout;
      @(negedge clk);
      cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
      step(3);
      chk("acc_ack_release", {31'd0, ack}, 32'd0);
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_reg1", reg1, 8'h00);
      chk("rst_reg2", reg2, 8'h00);
      chk("rst_status", status, 8'h00);
      chk("rst_ctrl", {dout_en, ack, my_rd, my_wr, cs_reg1, cs_reg2, cs_reg3}, 7'b0);
      chk("rst_dout", dout, 8'h00);
      @(negedge clk); rst = 1'b1;
      step(2);

      // Write A5 to reg2, cycle-accurate
      @(negedge clk);
      addr = 2'd2; din = 8'hA5; cs_n = 1'b0; we_n = 1'b0;
      step(3);
      chk("wr_e3_my_wr", {31'd0, my_wr}, 32'd0);
      step(1);
      chk("wr_e4_my_wr", {31'd0, my_wr}, 32'd1);
      chk("wr_e4_sel", {29'd0, cs_reg1, cs_reg2, cs_reg3}, 32'b010);
      chk("wr_e4_ack", {31'd0, ack}, 32'd0);
      step(1);
      chk("wr_e5_ack", {31'd0, ack}, 32'd1);
      chk("wr_e5_my_wr", {31'd0, my_wr}, 32'd0);
      chk("wr_reg2", reg2, 8'hA5);
      chk("wr_reg1", reg1, 8'h00);
      chk("wr_reg3", reg3, 8'h00);
      @(negedge clk); cs_n = 1'b1; we_n = 1'b1;
      step(2);
      chk("wr_rel_e2_ack", {31'd0, ack}, 32'd1);
      step(1);
      chk("wr_rel_e3_ack", {31'd0, ack}, 32'd0);
      chk("wr_rel_sel", {29'd0, cs_reg1, cs_reg2, cs_reg3}, 32'd0);

      // Read reg2 back; release only oe_n to exercise the active-strobe exit
      @(negedge clk);
      addr = 2'd2; cs_n = 1'b0; oe_n = 1'b0;
      step(4);
      chk("rd_e4_ack", {31'd0, ack}, 32'd0);
      chk("rd_e4_dout_en", {31'd0, dout_en}, 32'd0);
      chk("rd_e4_my_rd", {31'd0, my_rd}, 32'd1);
      step(1);
      chk("rd_e5_ack", {31'd0, ack}, 32'd1);
      chk("rd_e5_dout_en", {31'd0, dout_en}, 32'd1);
      chk("rd_e5_dout", dout, 8'hA5);
      @(negedge clk); oe_n = 1'b1;
      step(2);
      chk("rd_rel_e2_dout", dout, 8'hA5);
      step(1);
      chk("rd_rel_e3_ctrl", {29'd0, ack, dout_en, my_rd}, 32'd0);
      chk("rd_rel_e3_dout", dout, 8'h00);
      @(negedge clk); cs_n = 1'b1;
      step(3);

      // Conflicting strobes
      @(negedge clk);
      addr = 2'd1; din = 8'hFF; cs_n = 1'b0; oe_n = 1'b0; we_n = 1'b0;
      step(3);
      chk("cf_status", status, 8'h01);
      step(5);
      chk("cf_ack", {31'd0, ack}, 32'd0);
      chk("cf_dout_en", {31'd0, dout_en}, 32'd0);
      chk("cf_reg1", reg1, 8'h00);
      @(negedge clk); cs_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
      step(3);
      bus_access(1'b1, 2'd0, 8'h00, q);
      chk("cf_status_read", q, 8'h01);
      bus_access(1'b0, 2'd0, 8'h01, q);
      chk("cf_w1c_status", status, 8'h00);

      // reg3 decode and readback
      bus_access(1'b0, 2'd3, 8'h5A, q);
      chk("r3_reg3", reg3, 8'h5A);
      chk("r3_reg2", reg2, 8'hA5);
      bus_access(1'b1, 2'd3, 8'h00, q);
      chk("r3_read", q, 8'h5A);

      // Reset during WR of 3C to reg1, strobe held through release
      @(negedge clk);
      addr = 2'd1; din = 8'h3C; cs_n = 1'b0; we_n = 1'b0;
      step(4);
      chk("mr_in_wr", {31'd0, my_wr}, 32'd1);
      rst = 1'b0;
      #1;
      chk("mr_reg1", reg1, 8'h00);
      chk("mr_reg2", reg2, 8'h00);
      chk("mr_ctrl", {dout_en, ack, my_rd, my_wr, cs_reg1, cs_reg2, cs_reg3}, 7'b0);
      @(negedge clk); rst = 1'b1;
      step(5);
      chk("mr_fresh_ack", {31'd0, ack}, 32'd1);
      chk("mr_fresh_reg1", reg1, 8'h3C);
      @(negedge clk); cs_n = 1'b1; we_n = 1'b1;
      step(3);
      chk("mr_rel_ack", {31'd0, ack}, 32'd0);

`ifdef BUS_TIMEOUT_EN
      // Stuck read strobe
      @(negedge clk);
      addr = 2'd1; cs_n = 1'b0; oe_n = 1'b0;
      step(5);
      chk("to_ack_up", {31'd0, ack}, 32'd1);
      step(3);
      chk("to_ack_hold4", {31'd0, ack}, 32'd1);
      step(1);
      chk("to_ack_drop", {31'd0, ack}, 32'd0);
      chk("to_status", status, 8'h02);
      step(10);
      chk("to_no_retry", {30'd0, ack, dout_en}, 32'd0);
      @(negedge clk); cs_n = 1'b1; oe_n = 1'b1;
      step(3);
      bus_access(1'b1, 2'd1, 8'h00, q);
      chk("to_reaccess", q, 8'h3C);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
